// File: rtl/risc16_pkg.sv
// risc16_pkg: shared opcode encodings, FSM state encodings and width defaults for the risc16 execute stage
package risc16_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  typedef logic [3:0] opcode_t;
  localparam opcode_t OP_ADD = 4'd0;
  localparam opcode_t OP_SUB = 4'd1;
  localparam opcode_t OP_AND = 4'd2;
  localparam opcode_t OP_OR  = 4'd3;
  localparam opcode_t OP_XOR = 4'd4;
  localparam opcode_t OP_SHL = 4'd5;
  localparam opcode_t OP_SHR = 4'd6;
  localparam opcode_t OP_MUL = 4'd7;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per cycle, low W bits of the product
module seq_multiplier #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int CW = $clog2(W);
  logic [W-1:0] acc, a, b;
  logic [CW-1:0] cnt;
  logic busy;
  // bit 0 is folded into the load so the last of W-1 iteration edges completes the product
  assign product = acc + (b[0] ? a : '0);
  assign done = busy && cnt == CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) {busy, cnt, acc, a, b} <= '0;
    else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(W - 1);
      acc <= op_b[0] ? op_a : '0;
      a <= op_a << 1;
      b <= op_b >> 1;
    end else if (busy) begin
      busy <= cnt != CW'(1);
      cnt <= cnt - 1'b1;
      acc <= product;
      a <= a << 1;
      b <= b >> 1;
    end
endmodule

// File: rtl/execute_unit.sv
// execute_unit: single-issue ALU with an iterative multiplier and a registered write-back port and flags
module execute_unit
  import risc16_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] rz_addr,
  input  logic [DATA_W-1:0] rx_val,
  input  logic [DATA_W-1:0] ry_val,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c
);
  logic [1:0] state;
  logic accept, mul_start, mul_done, is_alu, alu_c;
  logic [DATA_W-1:0] product, alu_res;
  logic [DATA_W:0] sum, diff;
  logic [ADDR_W-1:0] mul_rz;
  logic [3:0] sh;
  assign issue_ready = state != ST_MUL;
  assign accept = issue_valid && issue_ready;
  assign mul_start = accept && opcode == OP_MUL;
  assign is_alu = opcode <= OP_SHR;
  assign sum = {1'b0, rx_val} + {1'b0, ry_val};
  assign diff = {1'b0, rx_val} - {1'b0, ry_val};
  assign sh = ry_val[3:0];
  assign alu_res = opcode == OP_ADD ? sum[DATA_W-1:0]
                 : opcode == OP_SUB ? diff[DATA_W-1:0]
                 : opcode == OP_AND ? rx_val & ry_val
                 : opcode == OP_OR  ? rx_val | ry_val
                 : opcode == OP_XOR ? rx_val ^ ry_val
                 : opcode == OP_SHL ? rx_val << sh
                 : rx_val >> sh;
  assign alu_c = opcode == OP_ADD ? sum[DATA_W] : opcode == OP_SUB ? diff[DATA_W] : 1'b0;
  seq_multiplier #(.W(DATA_W)) u_mul (
    .clk(clk),
    .rst(reset),
    .start(mul_start),
    .op_a(rx_val),
    .op_b(ry_val),
    .done(mul_done),
    .product(product)
  );
  // DONE accepts like IDLE, so a MUL issued there restarts the multiplier
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else if (state == ST_MUL) state <= mul_done ? ST_DONE : ST_MUL;
    else state <= mul_start ? ST_MUL : ST_IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      reg_wr <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      mul_rz <= '0;
    end else begin
      reg_wr <= 1'b0;
      if (mul_start) mul_rz <= rz_addr;
      if (mul_done) begin
        reg_wr <= 1'b1;
        wb_addr <= mul_rz;
        wb_data <= product;
        flag_z <= product == '0;
        flag_c <= 1'b0;
      end else if (accept && is_alu) begin
        reg_wr <= 1'b1;
        wb_addr <= rz_addr;
        wb_data <= alu_res;
        flag_z <= alu_res == '0;
        flag_c <= alu_c;
      end
    end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: randomized and directed checks of execute_unit against a cycle-level behavioural model
module tb_execute_unit;
  localparam int DW = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic reset, issue_valid, issue_ready, reg_wr, flag_z, flag_c;
  logic [3:0] opcode;
  logic [AW-1:0] rz_addr, wb_addr;
  logic [DW-1:0] rx_val, ry_val, wb_data;
  int n_pass = 0, n_total = 0;
  longint e = 0, ready_edge = 0, mul_edge = 0;
  bit mul_pend = 0, m_wr = 0, m_z = 0, m_c = 0;
  longint mul_rz = 0, mul_p = 0, m_addr = 0, m_data = 0;
  int wr_seen;
  always #5 clk = ~clk;
  execute_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .rz_addr(rz_addr), .rx_val(rx_val), .ry_val(ry_val),
    .reg_wr(reg_wr), .wb_addr(wb_addr), .wb_data(wb_data), .flag_z(flag_z), .flag_c(flag_c)
  );
  task automatic check(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
  endtask
  // model: ALU results appear after the accepting edge, MUL results 15 edges later, no issue for 16 edges
  task automatic model_edge();
    longint a = rx_val, b = ry_val, r = 0;
    bit ready = e >= ready_edge;
    m_wr = 0;
    if (reset) begin
      m_addr = 0; m_data = 0; m_z = 0; m_c = 0; mul_pend = 0; ready_edge = 0;
    end else if (mul_pend && e == mul_edge) begin
      m_wr = 1; m_addr = mul_rz; m_data = mul_p; m_z = mul_p == 0; m_c = 0; mul_pend = 0;
    end else if (issue_valid && ready && opcode == 7) begin
      mul_pend = 1; mul_edge = e + 15; ready_edge = e + 16; mul_rz = rz_addr; mul_p = (a * b) % 65536;
    end else if (issue_valid && ready && opcode < 7) begin
      m_c = 0;
      case (opcode)
        0: begin r = a + b; m_c = r > 65535; end
        1: begin r = a - b; m_c = a < b; end
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = a << (b % 16);
        default: r = a >> (b % 16);
      endcase
      m_wr = 1; m_addr = rz_addr; m_data = r & 65535; m_z = m_data == 0;
    end
  endtask
  task automatic compare();
    check("reg_wr", reg_wr, m_wr);
    check("issue_ready", issue_ready, e >= ready_edge);
    check("wb_addr", wb_addr, m_addr);
    check("wb_data", wb_data, m_data);
    check("flag_z", flag_z, m_z);
    check("flag_c", flag_c, m_c);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    e++;
    @(negedge clk);
    compare();
  endtask
  task automatic issue(input int op, input int rz, input int rx, input int ry);
    issue_valid = 1; opcode = 4'(op); rz_addr = AW'(rz); rx_val = DW'(rx); ry_val = DW'(ry);
    step();
  endtask
  task automatic idle();
    issue_valid = 0;
    step();
  endtask
  task automatic check_reset_outputs();
    check("rst_reg_wr", reg_wr, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_flag_z", flag_z, 0);
    check("rst_flag_c", flag_c, 0);
    check("rst_issue_ready", issue_ready, 1);
  endtask
  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 'hFFFF;
      2: return $urandom_range(0, 20);
      default: return $urandom_range(0, 'hFFFF);
    endcase
  endfunction
  initial begin
    reset = 1; issue_valid = 0; opcode = 0; rz_addr = 0; rx_val = 0; ry_val = 0;
    step();
    step();
    check_reset_outputs();
    reset = 0;
    idle();
    issue(0, 3, 'hFFFF, 1);
    check("add_reg_wr", reg_wr, 1);
    check("add_wb_addr", wb_addr, 3);
    check("add_wb_data", wb_data, 0);
    check("add_flag_z", flag_z, 1);
    check("add_flag_c", flag_c, 1);
    check("model_add_data", m_data, 0);
    issue(1, 0, 5, 7);
    check("sub_wb_data", wb_data, 'hFFFE);
    check("sub_flag_c", flag_c, 1);
    check("sub_flag_z", flag_z, 0);
    check("model_sub_data", m_data, 'hFFFE);
    issue(4, 1, 'h00FF, 'h0F0F);
    check("xor_reg_wr", reg_wr, 1);
    check("xor_wb_data", wb_data, 'h0FF0);
    check("xor_flag_c", flag_c, 0);
    issue(5, 2, 1, 'hF);
    check("shl_wb_data", wb_data, 'h8000);
    issue(6, 2, 'h8000, 'h10);
    check("shr_wb_data", wb_data, 'h8000);
    issue(0, 4, 'hFFFF, 1);
    issue(12, 6, 3, 4);
    check("nop_reg_wr", reg_wr, 0);
    check("nop_flag_z", flag_z, 1);
    check("nop_flag_c", flag_c, 1);
    check("nop_wb_addr", wb_addr, 4);
    issue(0, 5, 2, 3);
    check("add2_wb_data", wb_data, 5);
    idle();
    issue(7, 9, 300, 300);
    opcode = 0; rz_addr = 5; rx_val = 1; ry_val = 1;
    wr_seen = 0;
    for (int i = 1; i <= 15; i++) begin
      check("mul_ready_low", issue_ready, 0);
      wr_seen += int'(reg_wr);
      step();
    end
    check("mul_wr_early", wr_seen, 0);
    check("mul_reg_wr", reg_wr, 1);
    check("mul_wb_addr", wb_addr, 9);
    check("mul_wb_data", wb_data, 'h5F90);
    check("mul_ready_done", issue_ready, 1);
    check("model_mul_data", m_data, 'h5F90);
    step();
    check("post_mul_add", wb_data, 2);
    idle();
    issue(7, 9, 300, 300);
    issue_valid = 0;
    repeat (7) step();
    reset = 1;
    #1;
    check_reset_outputs();
    step();
    reset = 0;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      wr_seen += int'(reg_wr);
    end
    check("abort_no_wr", wr_seen, 0);
    issue(0, 1, 2, 2);
    check("abort_add_wr", reg_wr, 1);
    check("abort_add_data", wb_data, 4);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset = 1;
        step();
        reset = 0;
      end else begin
        issue_valid = $urandom_range(0, 3) != 0;
        opcode = $urandom_range(0, 3) == 0 ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        rz_addr = AW'($urandom_range(0, 15));
        rx_val = DW'(rnd_val());
        ry_val = DW'(rnd_val());
        step();
      end
    end
    issue_valid = 0;
    repeat (20) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
